// File: rtl/bj_pkg.sv
// ============================================================================
// bj_pkg : shared states, result codes and card constants for the table
// Revision 1.0
// ============================================================================
`default_nettype none

package bj_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DEAL    = 3'd1,
      ST_PLAYER  = 3'd2,
      ST_DRAW    = 3'd3,
      ST_DEALER  = 3'd4,
      ST_RESOLVE = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_WIN  = 2'b01;
   localparam logic [1:0] RES_LOSE = 2'b10;
   localparam logic [1:0] RES_PUSH = 2'b11;

   localparam logic [3:0] ACE        = 4'd1;
   localparam int         BUST_LIMIT = 21;

   // Out-of-range card codes still occupy a slot in the shoe and count as ten.
   function automatic logic [3:0] card_points(input logic [3:0] value);
      if (value == 4'd0 || value > 4'd10) begin
         return 4'd10;
      end
      return value;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bj_table_fsm_if.sv
// ============================================================================
// bj_table_fsm_if : player controls, card shoe handshake and table status
// Revision 1.0
// ============================================================================
`default_nettype none

interface bj_table_fsm_if #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 5
);

   logic                           start;
   logic                           hit;
   logic                           stand;
   logic                           card_req;
   logic                           card_valid;
   logic [3:0]                     card_value;
   logic [1:0]                     active_player;
   logic [NUM_PLAYERS*SCORE_W-1:0] player_score;
   logic [SCORE_W-1:0]             dealer_score;
   logic [2*NUM_PLAYERS-1:0]       result;
   logic [2:0]                     state_out;
   logic                           done;

   modport master (
      output start, hit, stand, card_valid, card_value,
      input  card_req, active_player, player_score, dealer_score,
             result, state_out, done
   );

   modport slave (
      input  start, hit, stand, card_valid, card_value,
      output card_req, active_player, player_score, dealer_score,
             result, state_out, done
   );

endinterface

`default_nettype wire

// File: rtl/bj_hand_score.sv
// ============================================================================
// bj_hand_score : hard total plus ace flag to best score and bust flag
// Revision 1.0
// ============================================================================
`default_nettype none

module bj_hand_score
   import bj_pkg::*;
#(
   parameter int SCORE_W = 5
) (
   input  wire logic [SCORE_W-1:0] hard,
   input  wire logic               ace,
   output logic      [SCORE_W-1:0] best,
   output logic                    bust
);

   // Testing hard <= 11 rather than hard+10 <= 21 keeps the sum from wrapping.
   always_comb begin
      best = hard;
      if (ace && (hard <= SCORE_W'(BUST_LIMIT - 10))) begin
         best = hard + SCORE_W'(10);
      end
      bust = (best > SCORE_W'(BUST_LIMIT));
   end

endmodule

`default_nettype wire

// File: rtl/bj_table_fsm.sv
// ============================================================================
// bj_table_fsm : blackjack table sequencer (deal, player turns, dealer, resolve)
// Revision 1.0
// ============================================================================
`default_nettype none

module bj_table_fsm
   import bj_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int SCORE_W      = 5,
   parameter int DEALER_STAND = 17
) (
   input  wire logic      CLOCK_50,
   input  wire logic      reset,
   bj_table_fsm_if.slave  bus
);

   localparam logic [3:0] LAST_DEAL = 4'(2 * NUM_PLAYERS + 1);

   state_t                                state_q, state_d;
   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   hard_q, hard_d;
   logic [NUM_PLAYERS-1:0]                ace_q, ace_d;
   logic [SCORE_W-1:0]                    dealer_hard_q, dealer_hard_d;
   logic                                  dealer_ace_q, dealer_ace_d;
   logic [1:0]                            seat_q, seat_d;
   logic [2:0]                            deal_seat_q, deal_seat_d;
   logic [3:0]                            deal_cnt_q, deal_cnt_d;
   logic                                  card_req_q, card_req_d;
   logic [2*NUM_PLAYERS-1:0]              result_q, result_d;

   logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   best_w;
   logic [NUM_PLAYERS-1:0]                bust_w;
   logic [SCORE_W-1:0]                    dealer_best_w;
   logic                                  dealer_bust_w;
   logic                                  consume_w;
   logic                                  is_ace_w;
   logic [SCORE_W-1:0]                    pts_w;
   logic [SCORE_W-1:0]                    cur_best_w;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_seat
      bj_hand_score #(.SCORE_W(SCORE_W)) u_hand (
         .hard (hard_q[g]),
         .ace  (ace_q[g]),
         .best (best_w[g]),
         .bust (bust_w[g])
      );
   end

   bj_hand_score #(.SCORE_W(SCORE_W)) u_dealer_hand (
      .hard (dealer_hard_q),
      .ace  (dealer_ace_q),
      .best (dealer_best_w),
      .bust (dealer_bust_w)
   );

   assign consume_w = card_req_q & bus.card_valid;
   assign is_ace_w  = (bus.card_value == ACE);
   assign pts_w     = SCORE_W'(card_points(bus.card_value));

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         hard_q        <= '0;
         ace_q         <= '0;
         dealer_hard_q <= '0;
         dealer_ace_q  <= 1'b0;
         seat_q        <= 2'd0;
         deal_seat_q   <= 3'd0;
         deal_cnt_q    <= 4'd0;
         card_req_q    <= 1'b0;
         result_q      <= '0;
      end else begin
         state_q       <= state_d;
         hard_q        <= hard_d;
         ace_q         <= ace_d;
         dealer_hard_q <= dealer_hard_d;
         dealer_ace_q  <= dealer_ace_d;
         seat_q        <= seat_d;
         deal_seat_q   <= deal_seat_d;
         deal_cnt_q    <= deal_cnt_d;
         card_req_q    <= card_req_d;
         result_q      <= result_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hard_d        = hard_q;
      ace_d         = ace_q;
      dealer_hard_d = dealer_hard_q;
      dealer_ace_d  = dealer_ace_q;
      seat_d        = seat_q;
      deal_seat_d   = deal_seat_q;
      deal_cnt_d    = deal_cnt_q;
      result_d      = result_q;
      card_req_d    = 1'b0;

      cur_best_w = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (seat_q == 2'(i)) begin
            cur_best_w = best_w[i];
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               hard_d        = '0;
               ace_d         = '0;
               dealer_hard_d = '0;
               dealer_ace_d  = 1'b0;
               seat_d        = 2'd0;
               deal_seat_d   = 3'd0;
               deal_cnt_d    = 4'd0;
               result_d      = '0;
               state_d       = ST_DEAL;
            end
         end

         ST_DEAL: begin
            card_req_d = !consume_w;
            if (consume_w) begin
               if (deal_seat_q == 3'(NUM_PLAYERS)) begin
                  dealer_hard_d = dealer_hard_q + pts_w;
                  dealer_ace_d  = dealer_ace_q | is_ace_w;
                  deal_seat_d   = 3'd0;
               end else begin
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     if (deal_seat_q == 3'(i)) begin
                        hard_d[i] = hard_q[i] + pts_w;
                        ace_d[i]  = ace_q[i] | is_ace_w;
                     end
                  end
                  deal_seat_d = deal_seat_q + 3'd1;
               end
               deal_cnt_d = deal_cnt_q + 4'd1;
               if (deal_cnt_q == LAST_DEAL) begin
                  seat_d  = 2'd0;
                  state_d = ST_PLAYER;
               end
            end
         end

         // A seat already at 21 or bust moves on before any hit/stand is looked at.
         ST_PLAYER: begin
            if ((cur_best_w >= SCORE_W'(BUST_LIMIT)) || bus.stand) begin
               if (seat_q == 2'(NUM_PLAYERS - 1)) begin
                  state_d = ST_DEALER;
               end else begin
                  seat_d = seat_q + 2'd1;
               end
            end else if (bus.hit) begin
               state_d = ST_DRAW;
            end
         end

         ST_DRAW: begin
            card_req_d = !consume_w;
            if (consume_w) begin
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (seat_q == 2'(i)) begin
                     hard_d[i] = hard_q[i] + pts_w;
                     ace_d[i]  = ace_q[i] | is_ace_w;
                  end
               end
               state_d = ST_PLAYER;
            end
         end

         ST_DEALER: begin
            if ((&bust_w) || (dealer_best_w >= SCORE_W'(DEALER_STAND))) begin
               state_d = ST_RESOLVE;
            end else begin
               card_req_d = !consume_w;
               if (consume_w) begin
                  dealer_hard_d = dealer_hard_q + pts_w;
                  dealer_ace_d  = dealer_ace_q | is_ace_w;
               end
            end
         end

         ST_RESOLVE: begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               if (bust_w[i]) begin
                  result_d[2*i +: 2] = RES_LOSE;
               end else if (dealer_bust_w || (best_w[i] > dealer_best_w)) begin
                  result_d[2*i +: 2] = RES_WIN;
               end else if (best_w[i] < dealer_best_w) begin
                  result_d[2*i +: 2] = RES_LOSE;
               end else begin
                  result_d[2*i +: 2] = RES_PUSH;
               end
            end
            state_d = ST_DONE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.card_req      = card_req_q;
      bus.active_player = seat_q;
      bus.dealer_score  = dealer_best_w;
      bus.result        = result_q;
      bus.state_out     = state_q;
      bus.done          = (state_q == ST_DONE);
      bus.player_score  = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         bus.player_score[i*SCORE_W +: SCORE_W] = best_w[i];
      end
   end

endmodule

`default_nettype wire
